// File: rtl/lzma2_crc_packer.sv
// Packs a 1..4 byte-per-word input stream into 32-byte chunks for the LZMA2 CRC stage,
// with one-chunk backpressure buffering, per-stream byte count and sticky format errors.
module lzma2_crc_packer #(
    parameter int MAX_BYTES = 32768
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic [4:0]   out_last_bytes,
    input  logic         out_ready,
    output logic [15:0]  stream_bytes,
    output logic         error,
    output logic [3:0]   error_code
);
    localparam int CHUNK_BYTES = 32;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid/data must hold until then, and ready never depends combinationally on valid.
    logic [255:0] r_acc;
    logic [5:0]   r_fill;
    logic         r_pending;
    logic         r_pend_last;
    logic [255:0] r_out_data;
    logic         r_out_valid;
    logic         r_out_last;
    logic [4:0]   r_out_last_bytes;
    logic [15:0]  r_stream_bytes;
    logic         r_first;
    logic         r_error;
    logic [3:0]   r_error_code;

    logic         w_accept;
    logic         w_drain;
    logic         w_out_free;
    logic         w_bad;
    logic         w_partial;
    logic         w_ovf;
    logic [15:0]  w_base;
    logic [16:0]  w_sum;
    logic [3:0]   w_err_code;
    logic         w_err_hit;
    logic         w_take;
    logic         w_complete;
    logic [31:0]  w_mask;
    logic [255:0] w_ins;
    logic [255:0] w_merged;
    logic [5:0]   w_new_fill;

    assign in_ready       = !r_pending;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;
    assign out_last_bytes = r_out_last_bytes;
    assign stream_bytes   = r_stream_bytes;
    assign error          = r_error;
    assign error_code     = r_error_code;

    assign w_accept   = in_valid && !r_pending;
    assign w_drain    = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // The first word of a stream counts from zero, so the limit check uses the reloaded base.
    assign w_base    = r_first ? 16'd0 : r_stream_bytes;
    assign w_sum     = {1'b0, w_base} + {14'd0, in_bytes};
    assign w_bad     = (in_bytes == 3'd0) || (in_bytes > 3'd4);
    assign w_partial = (in_bytes < 3'd4) && !in_last;
    assign w_ovf     = w_sum > 17'(MAX_BYTES);

    always_comb begin
        w_err_code = 4'd0;
        if (w_bad)
            w_err_code = 4'd3;
        else if (w_partial)
            w_err_code = 4'd2;
        else if (w_ovf)
            w_err_code = 4'd1;
    end

    assign w_err_hit = w_accept && !r_error && (w_err_code != 4'd0);
    assign w_take    = w_accept && !r_error && (w_err_code == 4'd0);

    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (in_bytes)
            3'd1:    w_mask = 32'h0000_00FF;
            3'd2:    w_mask = 32'h0000_FFFF;
            3'd3:    w_mask = 32'h00FF_FFFF;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
    end

    // Bytes of acc above fill are always zero, so an OR merge leaves unused bytes zero.
    assign w_ins      = {224'd0, in_data & w_mask} << {r_fill, 3'b000};
    assign w_merged   = r_acc | w_ins;
    assign w_new_fill = r_fill + {3'b000, in_bytes};
    assign w_complete = w_take && ((w_new_fill == 6'(CHUNK_BYTES)) || in_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc            <= '0;
            r_fill           <= '0;
            r_pending        <= 1'b0;
            r_pend_last      <= 1'b0;
            r_out_data       <= '0;
            r_out_valid      <= 1'b0;
            r_out_last       <= 1'b0;
            r_out_last_bytes <= '0;
            r_stream_bytes   <= '0;
            r_first          <= 1'b1;
            r_error          <= 1'b0;
            r_error_code     <= '0;
        end else begin
            if (w_drain) begin
                r_out_valid      <= 1'b0;
                r_out_last       <= 1'b0;
                r_out_last_bytes <= '0;
            end
            if (r_pending && w_out_free) begin
                r_out_data       <= r_acc;
                r_out_valid      <= 1'b1;
                r_out_last       <= r_pend_last;
                r_out_last_bytes <= r_pend_last ? r_fill[4:0] : 5'd0;
                r_acc            <= '0;
                r_fill           <= '0;
                r_pending        <= 1'b0;
                r_pend_last      <= 1'b0;
            end else if (w_err_hit) begin
                r_error      <= 1'b1;
                r_error_code <= w_err_code;
                r_acc        <= '0;
                r_fill       <= '0;
            end else if (w_take) begin
                r_stream_bytes <= w_sum[15:0];
                r_first        <= in_last;
                if (w_complete && w_out_free) begin
                    r_out_data       <= w_merged;
                    r_out_valid      <= 1'b1;
                    r_out_last       <= in_last;
                    r_out_last_bytes <= in_last ? w_new_fill[4:0] : 5'd0;
                    r_acc            <= '0;
                    r_fill           <= '0;
                end else if (w_complete) begin
                    r_acc       <= w_merged;
                    r_fill      <= w_new_fill;
                    r_pending   <= 1'b1;
                    r_pend_last <= in_last;
                end else begin
                    r_acc  <= w_merged;
                    r_fill <= w_new_fill;
                end
            end
        end
    end
endmodule

// File: tb/tb_lzma2_crc_packer.sv
// Directed bench for lzma2_crc_packer: a default-limit instance plus a 64-byte-limit
// instance for the overflow case, selected by sel; beats are collected into got_q.
module tb_lzma2_crc_packer;
    logic         clk = 1'b0;
    logic         rst, clear, sel;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         drv_valid, in_last, out_ready;

    logic         m_in_ready, m_out_valid, m_out_last, m_error;
    logic [255:0] m_out_data;
    logic [4:0]   m_out_last_bytes;
    logic [15:0]  m_stream_bytes;
    logic [3:0]   m_error_code;
    logic         s_in_ready, s_out_valid, s_out_last, s_error;
    logic [255:0] s_out_data;
    logic [4:0]   s_out_last_bytes;
    logic [15:0]  s_stream_bytes;
    logic [3:0]   s_error_code;

    logic         o_in_ready, o_out_valid, o_out_last, o_error;
    logic [255:0] o_out_data;
    logic [4:0]   o_out_last_bytes;
    logic [15:0]  o_stream_bytes;
    logic [3:0]   o_error_code;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;
    int g_mul = 1;
    int g_add = 0;
    logic [261:0] exp_q[$];
    logic [261:0] got_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lzma2_crc_packer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_bytes(in_bytes), .in_valid(drv_valid & ~sel), .in_last(in_last),
        .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
        .out_last(m_out_last), .out_last_bytes(m_out_last_bytes), .out_ready(out_ready),
        .stream_bytes(m_stream_bytes), .error(m_error), .error_code(m_error_code)
    );

    lzma2_crc_packer #(.MAX_BYTES(64)) dut_s (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_bytes(in_bytes), .in_valid(drv_valid & sel), .in_last(in_last),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_last(s_out_last), .out_last_bytes(s_out_last_bytes), .out_ready(out_ready),
        .stream_bytes(s_stream_bytes), .error(s_error), .error_code(s_error_code)
    );

    assign o_in_ready       = sel ? s_in_ready       : m_in_ready;
    assign o_out_valid      = sel ? s_out_valid      : m_out_valid;
    assign o_out_last       = sel ? s_out_last       : m_out_last;
    assign o_error          = sel ? s_error          : m_error;
    assign o_out_data       = sel ? s_out_data       : m_out_data;
    assign o_out_last_bytes = sel ? s_out_last_bytes : m_out_last_bytes;
    assign o_stream_bytes   = sel ? s_stream_bytes   : m_stream_bytes;
    assign o_error_code     = sel ? s_error_code     : m_error_code;

    always @(negedge clk)
        if (!rst && o_out_valid && out_ready)
            got_q.push_back({o_out_last, o_out_last_bytes, o_out_data});

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, required completion before 100000");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] sb(input int j);
        return 8'(j * g_mul + g_add);
    endfunction

    function automatic logic [261:0] beat(input int start, input int n, input logic last,
                                          input logic [4:0] lb);
        logic [255:0] d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = sb(start + i);
        return {last, lb, d};
    endfunction

    task automatic chk(input string tag, input logic [261:0] obs, input logic [261:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int waited = 0;
        in_data = d; in_bytes = nb; in_last = last; drv_valid = 1'b1;
        while (!o_in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks = n_checks + 1;
        assert (waited < 200) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL in_ready_timeout: waited %0d cycles, required < 200", waited);
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
    endtask

    task automatic send_stream(input int start, input int nw, input logic [2:0] last_nb,
                               input logic last);
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            logic [2:0]  nb;
            nb = (w == nw - 1) ? last_nb : 3'd4;
            for (int k = 0; k < 4; k++)
                d[8*k +: 8] = (k >= int'(nb)) ? 8'hEE : sb(start + 4*w + k);
            send_word(d, nb, last && (w == nw - 1));
        end
    endtask

    task automatic check_beats(input string tag);
        int n;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_beat_count"}, 262'(got_q.size()), 262'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1; clear = 1'b0; sel = 1'b0; drv_valid = 1'b0;
        in_data = '0; in_bytes = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_last_bytes", o_out_last_bytes, 0);
        chk("rst_stream_bytes", o_stream_bytes, 0);
        chk("rst_error", {o_error, o_error_code}, 0);
        rst = 1'b0;

        // Eight full words, last on word 8: one beat carrying 0x00..0x1F.
        g_mul = 1; g_add = 0;
        exp_q.push_back(beat(0, 32, 1'b1, 5'd0));
        send_stream(0, 8, 3'd4, 1'b1);
        chk("t1_latency_valid", o_out_valid, 1);
        chk("t1_last", {o_out_last, o_out_last_bytes}, {1'b1, 5'd0});
        chk("t1_data", o_out_data, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        chk("t1_stream_bytes", o_stream_bytes, 32);
        check_beats("t1");

        // Ten words, the last carrying two bytes.
        g_add = 8'h40;
        exp_q.push_back(beat(0, 32, 1'b0, 5'd0));
        exp_q.push_back(beat(32, 6, 1'b1, 5'd6));
        send_stream(0, 10, 3'd2, 1'b1);
        chk("t2_last", {o_out_valid, o_out_last, o_out_last_bytes}, {1'b1, 1'b1, 5'd6});
        chk("t2_stream_bytes", o_stream_bytes, 38);
        check_beats("t2");

        // 24 words against 20 cycles of backpressure.
        g_mul = 3; g_add = 1;
        out_ready = 1'b0;
        exp_q.push_back(beat(0, 32, 1'b0, 5'd0));
        exp_q.push_back(beat(32, 32, 1'b0, 5'd0));
        exp_q.push_back(beat(64, 32, 1'b1, 5'd0));
        fork
            begin
                send_stream(0, 16, 3'd4, 1'b0);
                chk("t3_in_ready_low", o_in_ready, 0);
                send_stream(64, 8, 3'd4, 1'b1);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("t3_stream_bytes", o_stream_bytes, 96);
        check_beats("t3");

        // Partial word mid-stream.
        g_mul = 5; g_add = 7;
        send_stream(0, 2, 3'd4, 1'b0);
        send_word(32'h0033_2211, 3'd3, 1'b0);
        chk("t4_partial_err", {o_error, o_error_code}, {1'b1, 4'd2});
        chk("t4_stream_hold", o_stream_bytes, 8);
        send_stream(8, 3, 3'd4, 1'b1);
        check_beats("t4_dropped");
        chk("t4_sticky", {o_error, o_error_code}, {1'b1, 4'd2});
        pulse_clear();
        chk("t4_clear_err", {o_error, o_error_code}, 0);
        chk("t4_clear_stream", o_stream_bytes, 0);
        g_add = 9;
        exp_q.push_back(beat(0, 32, 1'b1, 5'd0));
        send_stream(0, 8, 3'd4, 1'b1);
        chk("t4_fresh_stream", o_stream_bytes, 32);
        check_beats("t4_fresh");

        // Bad byte counts outrank the partial-word error; a 3-byte last word is legal.
        send_word(32'h1122_3344, 3'd5, 1'b0);
        chk("t5_bad5", {o_error, o_error_code}, {1'b1, 4'd3});
        pulse_clear();
        send_word(32'h5566_7788, 3'd0, 1'b1);
        chk("t5_bad0", {o_error, o_error_code}, {1'b1, 4'd3});
        pulse_clear();
        g_mul = 1; g_add = 8'h20;
        exp_q.push_back(beat(0, 3, 1'b1, 5'd3));
        send_stream(0, 1, 3'd3, 1'b1);
        chk("t5_legal3", {o_error, o_stream_bytes}, {1'b0, 16'd3});
        check_beats("t5");

        // Back-to-back one-word streams: completion and drain share an edge with no bubble.
        g_mul = 7; g_add = 2;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(beat(0, 4, 1'b1, 5'd4));
            send_stream(0, 1, 3'd4, 1'b1);
        end
        chk("t6_cycles", 262'(cyc - c0), 4);
        chk("t6_stream_bytes", o_stream_bytes, 4);
        check_beats("t6");

        // 64-byte limit: word 17 overflows, the first two chunks are still delivered.
        sel = 1'b1;
        g_mul = 1; g_add = 8'h60;
        exp_q.push_back(beat(0, 32, 1'b0, 5'd0));
        exp_q.push_back(beat(32, 32, 1'b0, 5'd0));
        send_stream(0, 16, 3'd4, 1'b0);
        chk("t7_at_limit", {o_error, o_stream_bytes}, {1'b0, 16'd64});
        send_stream(64, 1, 3'd4, 1'b0);
        chk("t7_overflow", {o_error, o_error_code}, {1'b1, 4'd1});
        check_beats("t7");
        sel = 1'b0;

        // Reset while a chunk sits in the output register and another is half built.
        g_add = 8'h80;
        out_ready = 1'b0;
        send_stream(0, 11, 3'd4, 1'b0);
        chk("t8_held", o_out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t8_rst_state", {o_out_valid, o_in_ready, o_stream_bytes}, {1'b0, 1'b1, 16'd0});
        out_ready = 1'b1;
        g_add = 8'hA0;
        exp_q.push_back(beat(0, 32, 1'b1, 5'd0));
        send_stream(0, 8, 3'd4, 1'b1);
        check_beats("t8");

        // Clear while a chunk is pending drops everything buffered.
        g_add = 8'hC0;
        out_ready = 1'b0;
        send_stream(0, 16, 3'd4, 1'b0);
        chk("t9_pending", o_in_ready, 0);
        pulse_clear();
        chk("t9_cleared", {o_out_valid, o_in_ready}, {1'b0, 1'b1});
        out_ready = 1'b1;
        check_beats("t9_none");
        g_add = 8'hD0;
        exp_q.push_back(beat(0, 8, 1'b1, 5'd8));
        send_stream(0, 2, 3'd4, 1'b1);
        check_beats("t9_fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
